axi_lite_arbiter: RTL

- Shares one downstream AXI-Lite slave port between NUM_M upstream AXI-Lite masters (e.g. PS GP port and an on-fabric config sequencer).
- Round-robin arbitration with exactly one transaction (read or write) in flight at a time.
- The downstream slave completes one transaction per IDLE→RESP cycle, so no pipelining across masters.
- Upstream signals are flattened vectors; master i occupies slice [i*W +: W].

---
 rtl/axi_lite_arbiter.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite slave among NUM_M masters, one transaction in flight.
// Optional watchdog abort with error response enabled by defining AXI_ARB_TIMEOUT_EN.
module axi_lite_arbiter #(
    parameter int NUM_M   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_M*ADDR_W-1:0]       S_AWADDR,
    input  logic [NUM_M*3-1:0]            S_AWPROT,
    input  logic [NUM_M-1:0]              S_AWVALID,
    output logic [NUM_M-1:0]              S_AWREADY,
    input  logic [NUM_M*DATA_W-1:0]       S_WDATA,
    input  logic [NUM_M*(DATA_W/8)-1:0]   S_WSTRB,
    input  logic [NUM_M-1:0]              S_WVALID,
    output logic [NUM_M-1:0]              S_WREADY,
    input  logic [NUM_M-1:0]              S_BREADY,
    output logic [NUM_M-1:0]              S_BVALID,
    output logic [NUM_M*2-1:0]            S_BRESP,
    input  logic [NUM_M*ADDR_W-1:0]       S_ARADDR,
    input  logic [NUM_M*3-1:0]            S_ARPROT,
    input  logic [NUM_M-1:0]              S_ARVALID,
    output logic [NUM_M-1:0]              S_ARREADY,
    input  logic [NUM_M-1:0]              S_RREADY,
    output logic [NUM_M-1:0]              S_RVALID,
    output logic [NUM_M*DATA_W-1:0]       S_RDATA,
    output logic [NUM_M*2-1:0]            S_RRESP,
    output logic [ADDR_W-1:0]             M_AWADDR,
    output logic [2:0]                    M_AWPROT,
    output logic                          M_AWVALID,
    input  logic                          M_AWREADY,
    output logic [DATA_W-1:0]             M_WDATA,
    output logic [DATA_W/8-1:0]           M_WSTRB,
    output logic                          M_WVALID,
    input  logic                          M_WREADY,
    input  logic                          M_BVALID,
    input  logic [1:0]                    M_BRESP,
    output logic                          M_BREADY,
    output logic [ADDR_W-1:0]             M_ARADDR,
    output logic [2:0]                    M_ARPROT,
    output logic                          M_ARVALID,
    input  logic                          M_ARREADY,
    input  logic                          M_RVALID,
    input  logic [DATA_W-1:0]             M_RDATA,
    input  logic [1:0]                    M_RRESP,
    output logic                          M_RREADY,
    output logic [$clog2(NUM_M)-1:0]      grant_id,
    output logic                          timeout
);

    localparam int GW = $clog2(NUM_M);
    localparam int SW = DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_ERR_WR,
        ST_ERR_RD
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_rrPtr;
    logic            r_awDone;
    logic            r_wDone;
    logic [NUM_M-1:0] w_wreq;
    logic [NUM_M-1:0] w_rreq;
    logic [GW-1:0]   w_winner;
    logic            w_found;
    logic            w_winnerWr;
    logic            w_awHs;
    logic            w_wHs;
    logic            w_abort;

    assign w_wreq   = S_AWVALID & S_WVALID;
    assign w_rreq   = S_ARVALID;
    assign grant_id = r_grant;

    // Scan starts just after the last grantee so every requester is reached within NUM_M grants.
    always_comb begin
        int idx;
        idx        = 0;
        w_found    = 1'b0;
        w_winner   = '0;
        w_winnerWr = 1'b0;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = (int'(r_rrPtr) + k) % NUM_M;
            if (!w_found && (w_wreq[idx] || w_rreq[idx])) begin
                w_found    = 1'b1;
                w_winner   = GW'(idx);
                w_winnerWr = w_wreq[idx];
            end
        end
    end

    always_comb begin
        int g;
        g         = int'(r_grant);
        w_next    = r_state;
        w_awHs    = 1'b0;
        w_wHs     = 1'b0;
        S_AWREADY = '0;
        S_WREADY  = '0;
        S_BVALID  = '0;
        S_BRESP   = '0;
        S_ARREADY = '0;
        S_RVALID  = '0;
        S_RDATA   = '0;
        S_RRESP   = '0;
        M_AWADDR  = '0;
        M_AWPROT  = '0;
        M_AWVALID = 1'b0;
        M_WDATA   = '0;
        M_WSTRB   = '0;
        M_WVALID  = 1'b0;
        M_BREADY  = 1'b0;
        M_ARADDR  = '0;
        M_ARPROT  = '0;
        M_ARVALID = 1'b0;
        M_RREADY  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next = w_winnerWr ? ST_WR_ADDR : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR: begin
                M_AWADDR     = S_AWADDR[g*ADDR_W +: ADDR_W];
                M_AWPROT     = S_AWPROT[g*3 +: 3];
                M_AWVALID    = S_AWVALID[g] & ~r_awDone;
                M_WDATA      = S_WDATA[g*DATA_W +: DATA_W];
                M_WSTRB      = S_WSTRB[g*SW +: SW];
                M_WVALID     = S_WVALID[g] & ~r_wDone;
                S_AWREADY[g] = M_AWREADY & ~r_awDone;
                S_WREADY[g]  = M_WREADY & ~r_wDone;
                w_awHs       = M_AWVALID & M_AWREADY;
                w_wHs        = M_WVALID & M_WREADY;
                if ((r_awDone || w_awHs) && (r_wDone || w_wHs)) begin
                    w_next = ST_WR_RESP;
                end else if (w_abort) begin
                    w_next = ST_ERR_WR;
                end
            end
            ST_WR_RESP: begin
                S_BVALID[g]      = M_BVALID;
                S_BRESP[g*2 +: 2] = M_BRESP;
                M_BREADY         = S_BREADY[g];
                if (M_BVALID && S_BREADY[g]) begin
                    w_next = ST_IDLE;
                end else if (w_abort) begin
                    w_next = ST_ERR_WR;
                end
            end
            ST_RD_ADDR: begin
                M_ARADDR     = S_ARADDR[g*ADDR_W +: ADDR_W];
                M_ARPROT     = S_ARPROT[g*3 +: 3];
                M_ARVALID    = S_ARVALID[g];
                S_ARREADY[g] = M_ARREADY;
                if (M_ARVALID && M_ARREADY) begin
                    w_next = ST_RD_DATA;
                end else if (w_abort) begin
                    w_next = ST_ERR_RD;
                end
            end
            ST_RD_DATA: begin
                S_RVALID[g]               = M_RVALID;
                S_RDATA[g*DATA_W +: DATA_W] = M_RDATA;
                S_RRESP[g*2 +: 2]         = M_RRESP;
                M_RREADY                  = S_RREADY[g];
                if (M_RVALID && S_RREADY[g]) begin
                    w_next = ST_IDLE;
                end else if (w_abort) begin
                    w_next = ST_ERR_RD;
                end
            end
            // Error states never touch the downstream port; only the grantee sees SLVERR.
            ST_ERR_WR: begin
                S_BVALID[g]       = 1'b1;
                S_BRESP[g*2 +: 2] = 2'b10;
                if (S_BREADY[g]) begin
                    w_next = ST_IDLE;
                end
            end
            ST_ERR_RD: begin
                S_RVALID[g]                 = 1'b1;
                S_RRESP[g*2 +: 2]           = 2'b10;
                S_RDATA[g*DATA_W +: DATA_W] = DATA_W'(32'hDEAD_BEEF);
                if (S_RREADY[g]) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rrPtr  <= GW'(NUM_M - 1);
            r_awDone <= 1'b0;
            r_wDone  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_found) begin
                r_grant <= w_winner;
                r_rrPtr <= w_winner;
            end
            if (w_next == ST_IDLE) begin
                r_awDone <= 1'b0;
                r_wDone  <= 1'b0;
            end else begin
                if (w_awHs) r_awDone <= 1'b1;
                if (w_wHs)  r_wDone  <= 1'b1;
            end
        end
    end

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_counting;
    logic             w_enterErr;

    assign w_counting = (r_state == ST_WR_ADDR) || (r_state == ST_WR_RESP) ||
                        (r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA);
    assign w_abort    = w_counting && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_enterErr = w_counting && ((w_next == ST_ERR_WR) || (w_next == ST_ERR_RD));
    assign timeout    = r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_enterErr;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_counting) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unusedTimeout;

    assign w_unusedTimeout = (TIMEOUT != 0);
    assign w_abort         = 1'b0;
    assign timeout         = 1'b0;
`endif

endmodule
